// File: rtl/sl_preceptron_seq.sv
// Purpose: job sequencer for a perceptron core; it loads weights, streams data, then collects the result.
// Latency: memory writes and data beats appear one cycle after they are accepted; a result follows core_done or a timeout by one cycle.
// Backpressure: w_ready and d_ready depend on state only; the result is held stable until res_ready is asserted.
module sl_preceptron_seq #(
    parameter int DATA_IN_LANES  = 4,
    parameter int DATA_IN_WIDTH  = 8,
    parameter int WEIGHTS_WIDTH  = 8,
    parameter int MEM_ADDR_WIDTH = 16,
    parameter int VECTOR_LENGTH  = 128,
    parameter int SUM_WIDTH      = DATA_IN_WIDTH + WEIGHTS_WIDTH + $clog2(VECTOR_LENGTH),
    parameter int TIMEOUT_CCS    = 64
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   start,
    input  logic                                   reuse_w,
    input  logic [SUM_WIDTH-1:0]                   threshold,
    input  logic                                   abort,
    input  logic                                   w_valid,
    output logic                                   w_ready,
    input  logic [WEIGHTS_WIDTH-1:0]               w_data,
    input  logic                                   d_valid,
    output logic                                   d_ready,
    input  logic [DATA_IN_LANES*DATA_IN_WIDTH-1:0] d_data,
    output logic                                   mem_wen,
    output logic [MEM_ADDR_WIDTH-1:0]              mem_addr,
    output logic [WEIGHTS_WIDTH-1:0]               mem_wdata,
    output logic                                   data_valid,
    output logic [DATA_IN_LANES*DATA_IN_WIDTH-1:0] data_in,
    output logic [SUM_WIDTH-1:0]                   cfg_ai_threshold,
    input  logic                                   core_done,
    input  logic [SUM_WIDTH-1:0]                   status_ai_sum,
    input  logic                                   status_ai_comparator,
    output logic                                   res_valid,
    input  logic                                   res_ready,
    output logic [SUM_WIDTH-1:0]                   res_sum,
    output logic                                   res_comp,
    output logic                                   res_err,
    output logic                                   busy
);

    localparam int BEATS = VECTOR_LENGTH / DATA_IN_LANES;
    localparam int WCW   = $clog2(VECTOR_LENGTH + 1);
    localparam int DCW   = $clog2(BEATS + 1);
    localparam int TCW   = $clog2(TIMEOUT_CCS + 1);
    localparam logic [WCW-1:0] W_LAST = WCW'(VECTOR_LENGTH - 1);
    localparam logic [DCW-1:0] D_LAST = DCW'(BEATS - 1);
    localparam logic [TCW-1:0] T_LAST = TCW'(TIMEOUT_CCS - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        LOAD_W   = 3'd1,
        STREAM   = 3'd2,
        WAIT_RES = 3'd3,
        RESULT   = 3'd4
    } state_t;

    state_t          state, state_nxt;
    logic [WCW-1:0]  w_cnt;
    logic [DCW-1:0]  d_cnt;
    logic [TCW-1:0]  t_cnt;

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Next state and state-decoded handshakes; abort overrides every other event.
    always_comb begin
        state_nxt = state;
        w_ready   = 1'b0;
        d_ready   = 1'b0;
        res_valid = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if (start) state_nxt = reuse_w ? STREAM : LOAD_W;
            end
            LOAD_W: begin
                w_ready = 1'b1;
                if (w_valid && (w_cnt == W_LAST)) state_nxt = STREAM;
            end
            STREAM: begin
                d_ready = 1'b1;
                if (d_valid && (d_cnt == D_LAST)) state_nxt = WAIT_RES;
            end
            WAIT_RES: begin
                if (core_done || (t_cnt == T_LAST)) state_nxt = RESULT;
            end
            RESULT: begin
                res_valid = 1'b1;
                if (res_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        if (abort) state_nxt = IDLE;
    end

    // Datapath: counters, registered core-side outputs and result capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_cnt            <= '0;
            d_cnt            <= '0;
            t_cnt            <= '0;
            mem_wen          <= 1'b0;
            mem_addr         <= '0;
            mem_wdata        <= '0;
            data_valid       <= 1'b0;
            data_in          <= '0;
            cfg_ai_threshold <= '0;
            res_sum          <= '0;
            res_comp         <= 1'b0;
            res_err          <= 1'b0;
        end else begin
            mem_wen    <= 1'b0;
            data_valid <= 1'b0;
            data_in    <= '0;
            if (abort) begin
                w_cnt <= '0;
                d_cnt <= '0;
                t_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start) begin
                            cfg_ai_threshold <= threshold;
                            w_cnt            <= '0;
                            d_cnt            <= '0;
                            t_cnt            <= '0;
                        end
                    end
                    LOAD_W: begin
                        if (w_valid) begin
                            mem_wen   <= 1'b1;
                            mem_addr  <= MEM_ADDR_WIDTH'(w_cnt);
                            mem_wdata <= w_data;
                            w_cnt     <= (w_cnt == W_LAST) ? '0 : w_cnt + 1'b1;
                        end
                    end
                    STREAM: begin
                        if (d_valid) begin
                            data_valid <= 1'b1;
                            data_in    <= d_data;
                            d_cnt      <= (d_cnt == D_LAST) ? '0 : d_cnt + 1'b1;
                        end
                    end
                    WAIT_RES: begin
                        // A core result on the final timeout cycle still wins over the error.
                        if (core_done) begin
                            res_sum  <= status_ai_sum;
                            res_comp <= status_ai_comparator;
                            res_err  <= 1'b0;
                            t_cnt    <= '0;
                        end else if (t_cnt == T_LAST) begin
                            res_sum  <= '0;
                            res_comp <= 1'b0;
                            res_err  <= 1'b1;
                            t_cnt    <= '0;
                        end else begin
                            t_cnt <= t_cnt + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_sl_preceptron_seq.sv
// Purpose: scoreboard bench for sl_preceptron_seq driven by directed job scenarios.
// Latency: expected writes, beats and results are queued at acceptance and checked by a negedge monitor.
// Backpressure: exercises toggled valids and a result held under res_ready low.
module tb_sl_preceptron_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0, reuse_w = 1'b0, abort = 1'b0;
    logic [22:0] threshold = '0;
    logic        w_valid = 1'b0, w_ready;
    logic [7:0]  w_data = '0;
    logic        d_valid = 1'b0, d_ready;
    logic [31:0] d_data = '0;
    logic        mem_wen;
    logic [15:0] mem_addr;
    logic [7:0]  mem_wdata;
    logic        data_valid;
    logic [31:0] data_in;
    logic [22:0] cfg_ai_threshold;
    logic        core_done = 1'b0;
    logic [22:0] status_ai_sum = '0;
    logic        status_ai_comparator = 1'b0;
    logic        res_valid, res_ready = 1'b0;
    logic [22:0] res_sum;
    logic        res_comp, res_err, busy;

    sl_preceptron_seq dut (
        .clk(clk), .rst(rst), .start(start), .reuse_w(reuse_w), .threshold(threshold),
        .abort(abort), .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data),
        .d_valid(d_valid), .d_ready(d_ready), .d_data(d_data),
        .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .data_valid(data_valid), .data_in(data_in), .cfg_ai_threshold(cfg_ai_threshold),
        .core_done(core_done), .status_ai_sum(status_ai_sum),
        .status_ai_comparator(status_ai_comparator),
        .res_valid(res_valid), .res_ready(res_ready), .res_sum(res_sum),
        .res_comp(res_comp), .res_err(res_err), .busy(busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;

    logic [23:0] exp_w[$];   // {addr[15:0], data[7:0]}
    logic [31:0] exp_d[$];
    logic [24:0] exp_r[$];   // {sum[22:0], comp, err}

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, got, want, $time);
        end
    endtask

    function automatic logic [31:0] beat_of(input int j);
        logic [31:0] r;
        for (int l = 0; l < 4; l++) r[l*8 +: 8] = 8'(4 * j + l);
        return r;
    endfunction

    // Monitor: pop and compare whenever the DUT presents a write, a beat or a result handshake.
    always @(negedge clk) begin
        if (!rst) begin
            if (mem_wen) begin
                if (exp_w.size() == 0) chk("unexpected_mem_wen", 1, 0);
                else chk("mem_write", {mem_addr, mem_wdata}, exp_w.pop_front());
            end
            if (data_valid) begin
                if (exp_d.size() == 0) chk("unexpected_data_valid", 1, 0);
                else chk("data_beat", data_in, exp_d.pop_front());
            end else begin
                chk("data_in_zero_when_idle", data_in, 0);
            end
            chk("wen_and_stream_exclusive", mem_wen & data_valid, 0);
            if (res_valid && res_ready) begin
                if (exp_r.size() == 0) chk("unexpected_result", 1, 0);
                else chk("result", {res_sum, res_comp, res_err}, exp_r.pop_front());
            end
        end
    end

    task automatic start_job(input logic [22:0] thr, input logic reuse);
        start = 1'b1; reuse_w = reuse; threshold = thr;
        @(posedge clk); #1;
        start = 1'b0; reuse_w = 1'b0;
        chk("busy_after_start", busy, 1);
        chk("threshold_latched", cfg_ai_threshold, thr);
        if (reuse) chk("d_ready_cycle_after_start", d_ready, 1);
        else       chk("w_ready_cycle_after_start", w_ready, 1);
    endtask

    task automatic send_weights(input bit toggle);
        int i = 0; int guard = 0; bit ph = 1'b0;
        while (i < 128 && guard < 2000) begin
            w_valid = toggle ? ph : 1'b1;
            w_data  = 8'(i);
            if (w_valid && w_ready) begin
                exp_w.push_back({16'(i), 8'(i)});
                i++;
            end
            @(posedge clk); #1;
            guard++; ph = ~ph;
        end
        w_valid = 1'b0;
        chk("weight_load_finished", i, 128);
    endtask

    task automatic send_data(input bit toggle, input int stop_at);
        int j = 0; int guard = 0; bit ph = 1'b0;
        while (j < stop_at && guard < 2000) begin
            d_valid = toggle ? ph : 1'b1;
            d_data  = beat_of(j);
            if (d_valid && d_ready) begin
                exp_d.push_back(beat_of(j));
                j++;
            end
            @(posedge clk); #1;
            guard++; ph = ~ph;
        end
        d_valid = 1'b0;
        chk("data_stream_progress", j, stop_at);
    endtask

    task automatic core_result(input int delay, input logic [22:0] sum, input logic comp);
        repeat (delay) begin @(posedge clk); #1; end
        core_done = 1'b1; status_ai_sum = sum; status_ai_comparator = comp;
        exp_r.push_back({sum, comp, 1'b0});
        @(posedge clk); #1;
        core_done = 1'b0; status_ai_sum = '0; status_ai_comparator = 1'b0;
    endtask

    task automatic take_result();
        int n = 0;
        res_ready = 1'b1;
        while (!res_valid && n < 200) begin @(posedge clk); #1; n++; end
        chk("result_presented", res_valid, 1);
        @(posedge clk); #1;
        res_ready = 1'b0;
        chk("res_valid_falls_after_handshake", res_valid, 0);
        chk("idle_after_handshake", busy, 0);
    endtask

    task automatic expect_no_result(input string name);
        logic seen = 1'b0;
        repeat (80) begin @(posedge clk); #1; seen |= res_valid | busy; end
        chk(name, seen, 0);
    endtask

    task automatic full_job(input logic [22:0] thr, input bit toggle, input logic [22:0] sum, input logic comp);
        start_job(thr, 1'b0);
        send_weights(toggle);
        send_data(toggle, 32);
        core_result(5, sum, comp);
        take_result();
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        logic [25:0] snap;
        int          n;
        logic        stable;

        // Reset state.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset_busy_ready", {busy, w_ready, d_ready, res_valid}, 0);
        chk("reset_mem_port", {mem_wen, mem_addr, mem_wdata}, 0);
        chk("reset_data_port", {data_valid, data_in}, 0);
        chk("reset_threshold", cfg_ai_threshold, 0);
        chk("reset_result", {res_sum, res_comp, res_err}, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Full job with weights.
        full_job(23'd1000, 1'b0, 23'd5000, 1'b1);

        // Reuse weights: no writes, stream begins the cycle after start.
        start_job(23'd2000, 1'b1);
        send_data(1'b0, 32);
        core_result(3, 23'd123, 1'b0);
        take_result();

        // Backpressure on both streams.
        full_job(23'd500, 1'b1, 23'd7777, 1'b1);

        // Timeout with the result held under res_ready low.
        start_job(23'd300, 1'b1);
        send_data(1'b0, 32);
        n = 0;
        while (!res_valid && n < 200) begin @(posedge clk); #1; n++; end
        chk("timeout_latency", n, 64);
        chk("timeout_result", {res_sum, res_comp, res_err}, {23'd0, 1'b0, 1'b1});
        snap = {res_valid, res_sum, res_comp, res_err};
        stable = 1'b1;
        repeat (10) begin
            @(posedge clk); #1;
            if ({res_valid, res_sum, res_comp, res_err} !== snap) stable = 1'b0;
        end
        chk("result_stable_while_not_ready", stable, 1);
        exp_r.push_back({23'd0, 1'b0, 1'b1});
        take_result();

        // core_done on the final timeout cycle: the core values win.
        start_job(23'd300, 1'b1);
        send_data(1'b0, 32);
        repeat (63) begin @(posedge clk); #1; end
        core_done = 1'b1; status_ai_sum = 23'd4242; status_ai_comparator = 1'b1;
        exp_r.push_back({23'd4242, 1'b1, 1'b0});
        @(posedge clk); #1;
        core_done = 1'b0; status_ai_sum = '0; status_ai_comparator = 1'b0;
        chk("coincident_done_result_valid", res_valid, 1);
        take_result();

        // start and abort together: stay idle, threshold untouched.
        start = 1'b1; abort = 1'b1; threshold = 23'd999;
        @(posedge clk); #1;
        start = 1'b0; abort = 1'b0;
        chk("start_abort_stays_idle", busy, 0);
        chk("start_abort_keeps_threshold", cfg_ai_threshold, 23'd300);

        // Abort at beat 10 of the stream, then a clean job.
        start_job(23'd1000, 1'b0);
        send_weights(1'b0);
        send_data(1'b0, 10);
        d_valid = 1'b1; d_data = beat_of(10); abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0; d_valid = 1'b0;
        chk("abort_busy_low", busy, 0);
        chk("abort_stream_quiet", {d_ready, data_valid, data_in}, 0);
        chk("abort_keeps_threshold", cfg_ai_threshold, 23'd1000);
        expect_no_result("no_result_after_abort");
        full_job(23'd1000, 1'b0, 23'd5000, 1'b1);

        // Reset at beat 10 of the stream, then a clean job.
        start_job(23'd1000, 1'b1);
        send_data(1'b0, 10);
        @(negedge clk); #1;
        rst = 1'b1;
        #1;
        chk("reset_mid_job_busy_low", {busy, d_ready, data_valid}, 0);
        chk("reset_mid_job_threshold", cfg_ai_threshold, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        expect_no_result("no_result_after_reset");
        full_job(23'd1000, 1'b0, 23'd5000, 1'b1);

        repeat (3) @(posedge clk);
        chk("all_expected_consumed", {16'(exp_w.size()), 16'(exp_d.size()), 16'(exp_r.size())}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
